// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache: 2**INDEX_W lines of 4 words, filled over a req/ack bus.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module inst_cache #(
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 26 - INDEX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  output logic        stall_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state_q;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES][4];
  logic [27:0]        line_q;
  logic [1:0]         cnt_q;
  logic               flush_pend_q;
  logic               mem_req_q;
  logic [31:0]        mem_addr_q;

  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic [1:0]         lk_off;
  logic               lk_hit;
  logic               in_idle;
  logic               miss;
  logic [INDEX_W-1:0] fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               fill_ack;
  logic               last_ack;
  logic [1:0]         cnt_d;
  logic               unused_addr_bits;

  // Tags cover address bits [TAG_W+INDEX_W+3:INDEX_W+4]; any higher bits alias.
  assign lk_off   = rom_addr_i[3:2];
  assign lk_idx   = rom_addr_i[INDEX_W+3:4];
  assign lk_tag   = rom_addr_i[TAG_W+INDEX_W+3:INDEX_W+4];
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign in_idle  = (state_q == IDLE);
  assign miss     = in_idle && rom_ce_i && !lk_hit;

  assign fill_idx = line_q[INDEX_W-1:0];
  assign fill_tag = line_q[TAG_W+INDEX_W-1:INDEX_W];
  assign fill_ack = (state_q == FILL) && mem_ack_i;
  assign last_ack = fill_ack && (cnt_q == 2'd3);
  assign cnt_d    = cnt_q + 2'd1;

  assign unused_addr_bits = ^rom_addr_i[1:0];

  // Core-facing outputs are combinational so hits cost no cycle.
  always_comb begin
    rom_data_o = '0;
    stall_o    = 1'b0;
    if (!rst) begin
      if (state_q == FILL) begin
        stall_o = 1'b1;
      end else if (rom_ce_i) begin
        if (lk_hit) rom_data_o = data_q[lk_idx][lk_off];
        else        stall_o    = 1'b1;
      end
    end
  end

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      cnt_q        <= 2'd0;
      flush_pend_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush_i) valid_q <= '0;
          if (miss) begin
            state_q    <= FILL;
            line_q     <= rom_addr_i[31:4];
            cnt_q      <= 2'd0;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {rom_addr_i[31:4], 4'b0000};
          end
        end
        FILL: begin
          if (flush_i) flush_pend_q <= 1'b1;
          if (mem_ack_i) begin
            cnt_q <= cnt_d;
            if (cnt_q == 2'd3) begin
              state_q      <= IDLE;
              mem_req_q    <= 1'b0;
              flush_pend_q <= 1'b0;
              // A flush seen at any point of the fill wins over validating the new line.
              if (flush_pend_q || flush_i) valid_q <= '0;
              else                         valid_q[fill_idx] <= 1'b1;
            end else begin
              mem_addr_q <= {line_q, cnt_d, 2'b00};
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage arrays carry no reset; valid_q alone decides whether contents are usable.
  always_ff @(posedge clk) begin
    if (!rst && fill_ack) data_q[fill_idx][cnt_q] <= mem_data_i;
    if (!rst && last_ack) tag_q[fill_idx] <= fill_tag;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (in_idle && rom_ce_i && lk_hit && (hit_cnt_q != 32'hFFFF_FFFF))
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (miss && (miss_cnt_q != 32'hFFFF_FFFF))
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
